touch_key_gen: RTL and testbench

//  Generates touch-key press waveforms on an active-low touch_key line (idle 1, pressed 0).

---
 rtl/touch_key_pkg.sv | 17 +
 rtl/touch_tick_cnt.sv | 38 +++
 rtl/touch_key_gen.sv | 169 ++++++++++++++++
 tb/tb_touch_key_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/touch_key_pkg.sv
// rtl/touch_key_pkg.sv - shared FSM state type and default constants for the touch-key generator
package touch_key_pkg;

  localparam int TOUCH_CNT_W      = 16;
  localparam int TOUCH_GAP_CYC    = 25;
  localparam int TOUCH_BOUNCE_CYC = 4;
  localparam int TOUCH_BOUNCE_NUM = 3;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    PRESS,
    BOUNCE_OUT,
    GAP
  } touch_state_e;

endpackage

// File: rtl/touch_tick_cnt.sv
// rtl/touch_tick_cnt.sv - loadable saturating down-counter used for phase timing
module touch_tick_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count holds at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/touch_key_gen.sv
// rtl/touch_key_gen.sv - active-low touch-key press generator; optional edge bounce under TOUCH_BOUNCE_EN
module touch_key_gen
  import touch_key_pkg::*;
#(
  parameter int CNT_W      = TOUCH_CNT_W,
  parameter int GAP_CYC    = TOUCH_GAP_CYC,
  parameter int BOUNCE_CYC = TOUCH_BOUNCE_CYC,
  parameter int BOUNCE_NUM = TOUCH_BOUNCE_NUM
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] press_len,
  output logic             touch_key,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

  touch_state_e     state_q;
  logic             key_q, ready_q, busy_q, done_q;
  logic             accept, cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt, len_m1;

`ifdef TOUCH_BOUNCE_EN
  localparam int               PH_W     = $clog2(2 * BOUNCE_NUM);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * BOUNCE_NUM - 1);
  localparam logic [CNT_W-1:0] BNC_LOAD = CNT_W'(BOUNCE_CYC - 1);
  logic [PH_W-1:0]  ph_q;
  logic [CNT_W-1:0] len_m1_q;
`endif

  // Ready is high in IDLE and in the last GAP cycle, so a held request starts exactly GAP_CYC highs later.
  assign accept = start_valid && ready_q;
  assign len_m1 = (press_len == '0) ? '0 : press_len - CNT_W'(1);

  touch_tick_cnt #(.CNT_W(CNT_W)) u_tick (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (1'b1),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // Each phase loads (length-1) into the counter; the phase ends when the counter reads zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (accept) begin
      cnt_load = 1'b1;
`ifdef TOUCH_BOUNCE_EN
      cnt_val  = BNC_LOAD;
`else
      cnt_val  = len_m1;
`endif
    end else if (cnt_zero) begin
      case (state_q)
`ifdef TOUCH_BOUNCE_EN
        PRESS: begin
          cnt_load = 1'b1;
          cnt_val  = BNC_LOAD;
        end
        BOUNCE_IN: begin
          cnt_load = 1'b1;
          cnt_val  = (ph_q == PH_LAST) ? len_m1_q : BNC_LOAD;
        end
        BOUNCE_OUT: begin
          cnt_load = 1'b1;
          cnt_val  = (ph_q == PH_LAST) ? GAP_LOAD : BNC_LOAD;
        end
`else
        PRESS: begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer with registered outputs; an accept overrides the GAP-to-IDLE return on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      key_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TOUCH_BOUNCE_EN
      ph_q     <= '0;
      len_m1_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PRESS: begin
          if (cnt_zero) begin
            key_q <= 1'b1;
`ifdef TOUCH_BOUNCE_EN
            state_q <= BOUNCE_OUT;
            ph_q    <= '0;
`else
            state_q <= GAP;
            ready_q <= (GAP_CYC == 1);
`endif
          end
        end
`ifdef TOUCH_BOUNCE_EN
        BOUNCE_IN: begin
          if (cnt_zero) begin
            if (ph_q == PH_LAST) begin
              state_q <= PRESS;
              key_q   <= 1'b0;
            end else begin
              ph_q  <= ph_q + PH_W'(1);
              key_q <= ~ph_q[0];
            end
          end
        end
        BOUNCE_OUT: begin
          if (cnt_zero) begin
            if (ph_q == PH_LAST) begin
              state_q <= GAP;
              key_q   <= 1'b1;
              ready_q <= (GAP_CYC == 1);
            end else begin
              ph_q  <= ph_q + PH_W'(1);
              key_q <= ph_q[0];
            end
          end
        end
`endif
        GAP: begin
          if (cnt_zero) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt == CNT_W'(1)) begin
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        key_q   <= 1'b0;
        busy_q  <= 1'b1;
        ready_q <= 1'b0;
`ifdef TOUCH_BOUNCE_EN
        state_q  <= BOUNCE_IN;
        ph_q     <= '0;
        len_m1_q <= len_m1;
`else
        state_q  <= PRESS;
`endif
      end
    end
  end

  assign touch_key   = key_q;
  assign start_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_touch_key_gen.sv
// tb/tb_touch_key_gen.sv - scoreboard bench for touch_key_gen
module tb_touch_key_gen;

  localparam int CNT_W = 16;
  localparam int GAP   = 25;
  localparam int BC    = 4;
  localparam int BN    = 3;

  logic             sys_clk, sys_rst, start_valid, start_ready, touch_key, busy, done;
  logic [CNT_W-1:0] press_len;

  typedef struct {
    int lows;
    int delay;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  touch_key_gen #(
    .CNT_W      (CNT_W),
    .GAP_CYC    (GAP),
    .BOUNCE_CYC (BC),
    .BOUNCE_NUM (BN)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .press_len   (press_len),
    .touch_key   (touch_key),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s act=%0d exp=%0d", name, act, exp);
  endtask

  // Reference: a press of length len is low L=max(len,1) steady cycles, plus bounce lows if enabled.
  function automatic exp_t model(input int len, input bit b2b);
    exp_t e;
    int   l;
    l = (len == 0) ? 1 : len;
`ifdef TOUCH_BOUNCE_EN
    e.lows  = l + 2 * BN * BC;
    e.delay = l + GAP + 4 * BN * BC;
`else
    e.lows  = l;
    e.delay = l + GAP;
`endif
    e.gap = b2b ? GAP : -1;
    return e;
  endfunction

  task automatic do_press(input int len, input bit b2b, input bit poke);
    int n;
    @(negedge sys_clk);
    if (!b2b) begin
      n = 0;
      while (!(start_ready && !busy) && n < 3000) begin
        @(negedge sys_clk);
        n++;
      end
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end
    start_valid = 1'b1;
    press_len   = len[CNT_W-1:0];
    n = 0;
    while (!start_ready && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!start_ready) begin
      check("accept_timeout", 0, 1);
      start_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    sb.push_back(model(len, b2b));
    #1;
    start_valid = 1'b0;
    press_len   = CNT_W'($urandom);
    if (poke) begin
      repeat (2) @(negedge sys_clk);
      start_valid = 1'b1;
      @(negedge sys_clk);
      start_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Monitor: measures each press from its first low sample to done and compares against the queue head.
  initial begin : monitor
    bit   in_seq;
    int   t, lows, hi_run;
    exp_t e;
    in_seq = 0;
    t      = 0;
    lows   = 0;
    hi_run = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        if (in_seq && sb.size() > 0) void'(sb.pop_front());
        in_seq = 0;
        hi_run = 0;
        continue;
      end
      if (in_seq) begin
        t++;
        if (done) begin
          in_seq = 0;
          if (sb.size() == 0) begin
            check("done_unmatched", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_delay", t, e.delay);
            check("low_cycles", lows, e.lows);
          end
        end else if (!touch_key) begin
          lows++;
        end
      end else if (done) begin
        check("done_spurious", 1, 0);
      end
      if (!in_seq && !touch_key) begin
        in_seq = 1;
        t      = 0;
        lows   = 1;
        if (sb.size() == 0) check("press_unexpected", 1, 0);
        else if (sb[0].gap >= 0) check("b2b_high_gap", hi_run, sb[0].gap);
      end
      hi_run = touch_key ? hi_run + 1 : 0;
    end
  end

  initial begin
    sys_rst     = 1'b1;
    start_valid = 1'b0;
    press_len   = '0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("rst_touch_key", int'(touch_key), 1);
    check("rst_start_ready", int'(start_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    do_press(100, 0, 0);
    do_press(0, 0, 0);
    do_press(10, 0, 0);
    do_press(10, 1, 0);
    do_press(10, 1, 1);
    do_press(10, 1, 0);
    for (int i = 0; i < 12; i++) begin
      do_press($urandom_range(0, 80), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end
    do_press(1, 1, 0);
    drain();

    do_press(100, 0, 0);
    repeat (49) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("midrst_touch_key", int'(touch_key), 1);
    check("midrst_start_ready", int'(start_ready), 1);
    check("midrst_busy", int'(busy), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (200) @(negedge sys_clk);
    check("midrst_queue", sb.size(), 0);

    do_press(5, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
